// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_structural.sv
// One-bit full adder built from gate primitives; the only arithmetic in the datapath.
module full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (cx_a, ab_x, cin);
  or  g_o1 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts two WIDTH-bit operands, pushes one bit pair per cycle
// through a single full adder (LSB first) and presents sum/cout/ovf on a handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic             msb_cin_q;
  logic [CW-1:0]    bit_cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder_structural u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

  assign sum  = sum_sh;
  assign cout = carry_q;
  assign ovf  = msb_cin_q ^ carry_q;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            bit_cnt <= '0;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
          sum_sh  <= (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
          carry_q <= fa_cout;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            msb_cin_q <= carry_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl: an 8-bit and a 1-bit build.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, cout8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;

  logic       iv1, ir1, ov1, or1, cin1, cout1, ovf1, busy1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one 8-bit operation at a negedge, measure latency (accept edge counts as 1),
  // check the result, then complete the output handshake.
  task automatic run8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                      input logic ci, input logic [7:0] es, input logic ec, input logic eo);
    int  lat;
    bit  seen;
    seen = 0;
    for (int i = 0; i < 20 && !ir8; i++) @(negedge clk);
    a8 = ai; b8 = bi; cin8 = ci; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov8) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_sum"}, 32'(sum8), 32'(es));
    check({tag, "_cout"}, 32'(cout8), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, ov8, ir8}, 32'b01);
  endtask

  task automatic run1(input string tag, input logic ai, input logic bi, input logic ci,
                      input logic es, input logic ec);
    int lat;
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !ir1; i++) @(negedge clk);
    a1 = ai; b1 = bi; cin1 = ci; iv1 = 1'b1;
    @(posedge clk);
    #1 iv1 = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov1) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_sum"}, 32'(sum1), 32'(es));
    check({tag, "_cout"}, 32'(cout1), 32'(ec));
    // Single-bit build: carry into the MSB is cin itself.
    check({tag, "_ovf"}, 32'(ovf1), 32'(ci ^ ec));
    or1 = 1'b1;
    @(posedge clk);
    #1 or1 = 1'b0;
  endtask

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    int         pulses;
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    iv1 = 0; or1 = 0; a1 = '0; b1 = '0; cin1 = 0;

    #22;
    check("reset_in_ready", 32'(ir8), 32'd1);
    check("reset_out_valid", 32'(ov8), 32'd0);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_sum", 32'(sum8), 32'd0);
    check("reset_cout_ovf", {30'd0, cout8, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run8("basic", 8'h5A, 8'h21, 1'b0, 8'h7B, 1'b0, 1'b0);
    run8("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("ovf_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // Backpressure: result must hold and a second request must be refused.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    for (int i = 0; i < 40 && !ov8; i++) @(negedge clk);
    check("bp_valid", 32'(ov8), 32'd1);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_sum", 32'(sum8), 32'h96);
      check("bp_cout_ovf", {30'd0, cout8, ovf8}, 32'b01);
      check("bp_in_ready", 32'(ir8), 32'd0);
      check("bp_out_valid", 32'(ov8), 32'd1);
      @(negedge clk);
    end
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    @(negedge clk);
    check("bp_not_accepted", {30'd0, busy8, ir8}, 32'b01);
    iv8 = 1'b0;
    @(negedge clk);

    // Reset while bit_cnt==3: accept edge leaves bit_cnt=0, three more edges reach 3.
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_busy", 32'(busy8), 32'd0);
    check("rst_run_ready_valid", {30'd0, ir8, ov8}, 32'b10);
    check("rst_run_sum", 32'(sum8), 32'd0);
    check("rst_run_cout_ovf", {30'd0, cout8, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) pulses++;
    end
    check("rst_run_no_pulse", 32'(pulses), 32'd0);
    run8("post_reset", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0);

    // 1-bit build: exhaustive truth table, index = {a,b,cin}.
    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run1($sformatf("w1_%0d", i), v[2], v[1], v[0], sum_tab[i], cout_tab[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
